// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and default geometry for the convolution stage-1 adder
// sequencer. It holds the sequencer state enum, the window-result tag that
// travels beside the adder data, and the default frame and kernel constants.
// -----------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // Tag coordinates are stored at a fixed width. Each user slices them down
    // to the width of its own output map.
    localparam int COORD_W = 16;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } conv_tag_t;

    localparam int DEF_IMG_WIDTH   = 28;
    localparam int DEF_IMG_HEIGHT  = 28;
    localparam int DEF_KERNEL      = 3;
    localparam int DEF_ADD_LATENCY = 2;

endpackage

// File: rtl/conv_tag_pipe.sv
// -----------------------------------------------------------------------------
// conv_tag_pipe
// A DEPTH-deep shift register of window tags. It advances in lock-step with
// the adder-stage chain.
//   clk, reset : clock and asynchronous active-low reset (all slots invalid)
//   en         : shift one slot; tag_in enters slot 0
//   tag_in     : tag for the adder input this cycle (valid=0 is a bubble)
//   tag_out    : last slot, aligned with the adder chain output
//   empty      : no slot holds a valid tag
//   last_only  : slots 0..DEPTH-2 hold no valid tag, so shifting in one more
//                bubble leaves the pipe empty
// -----------------------------------------------------------------------------
module conv_tag_pipe
    import conv_pkg::*;
#(
    parameter int DEPTH = DEF_ADD_LATENCY
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      en,
    input  conv_tag_t tag_in,
    output conv_tag_t tag_out,
    output logic      empty,
    output logic      last_only
);

    conv_tag_t slot_q [DEPTH];
    conv_tag_t slot_d [DEPTH];

    always_comb begin
        slot_d[0] = en ? tag_in : slot_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = en ? slot_q[i-1] : slot_q[i];
        end
    end

    always_comb begin
        empty     = 1'b1;
        last_only = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_q[i].valid) empty = 1'b0;
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (slot_q[i].valid) last_only = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign tag_out = slot_q[DEPTH-1];

endmodule

// File: rtl/conv_adder_sequencer.sv
// -----------------------------------------------------------------------------
// conv_adder_sequencer
// Sequences the shared convolution adder stages over one raster-order input
// feature map. It gates the adder enable, tracks which pipeline slots hold a
// complete KERNEL x KERNEL window, presents each result with its output
// coordinates, and pulses done once per frame.
//
// Optional feature: define SEQ_BACKPRESSURE_EN to add the outReady port. While
// a presented result is not accepted (outValid & ~outReady), the sequencer
// stalls. Without the macro, a result stays presented only until the next
// adderEnable, and downstream must capture it.
//
// Ports:
//   clk, reset   : clock and asynchronous active-low reset
//   start        : begin a frame (sampled in IDLE only)
//   pixelValid   : fetch side has a pixel
//   pixelReady   : pixel accepted this cycle when pixelValid (combinational)
//   adderEnable  : advance the adder chain this cycle (combinational)
//   outReady     : downstream accepts result (SEQ_BACKPRESSURE_EN only)
//   outValid     : adder output holds a valid window result
//   outRow/outCol: output-map coordinates of that result
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse after the last result has left
// -----------------------------------------------------------------------------
module conv_adder_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int KERNEL      = DEF_KERNEL,
    parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          pixelValid,
    output logic                          pixelReady,
    output logic                          adderEnable,
`ifdef SEQ_BACKPRESSURE_EN
    input  logic                          outReady,
`endif
    output logic                          outValid,
    output logic [$clog2(IMG_HEIGHT)-1:0] outRow,
    output logic [$clog2(IMG_WIDTH)-1:0]  outCol,
    output logic                          busy,
    output logic                          done
);

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_K    = ROW_W'(KERNEL - 1);
    localparam logic [COL_W-1:0] COL_K    = COL_W'(KERNEL - 1);

    conv_state_t      state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    conv_tag_t tag_in, tag_out;
    logic      pipe_empty, pipe_last_only;
    logic      stall, accept, last_pix;

`ifdef SEQ_BACKPRESSURE_EN
    assign stall = tag_out.valid & ~outReady;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        pixelReady  = (state_q == RUN) && !stall;
        accept      = pixelValid && pixelReady;
        // DRAIN keeps pushing bubbles until the last valid tag is out.
        adderEnable = accept || ((state_q == DRAIN) && !stall && !pipe_empty);
        last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);

        tag_in       = '0;
        tag_in.valid = accept && (row_q >= ROW_K) && (col_q >= COL_K);
        tag_in.row   = COORD_W'(row_q - ROW_K);
        tag_in.col   = COORD_W'(col_q - COL_K);
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pix) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave when this shift pushes the final valid tag out, so that
                // done coincides with the first cycle of an empty pipeline.
                if (pipe_empty || (adderEnable && pipe_last_only)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    conv_tag_pipe #(
        .DEPTH (ADD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .en        (adderEnable),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .empty     (pipe_empty),
        .last_only (pipe_last_only)
    );

    // Result outputs come straight from the last tag flop.
    assign outValid = tag_out.valid;
    assign outRow   = tag_out.row[ROW_W-1:0];
    assign outCol   = tag_out.col[COL_W-1:0];
    assign busy     = busy_q;
    assign done     = done_q;

    logic unused_tag_bits;
    assign unused_tag_bits = ^{tag_out.row[COORD_W-1:ROW_W], tag_out.col[COORD_W-1:COL_W]};

endmodule

// File: tb/tb_conv_adder_sequencer.sv
module tb_conv_adder_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4x4 frame, 3x3 kernel, 2-stage adder
    logic       start_s = 1'b0, pv_s = 1'b0;
    logic       pr_s, ae_s, ov_s, busy_s, done_s;
    logic [1:0] orow_s, ocol_s;
    // default 28x28 frame
    logic       start_b = 1'b0, pv_b = 1'b0;
    logic       pr_b, ae_b, ov_b, busy_b, done_b;
    logic [4:0] orow_b, ocol_b;
`ifdef SEQ_BACKPRESSURE_EN
    logic       or_s = 1'b1, or_b = 1'b1;
`endif

    conv_adder_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL(3), .ADD_LATENCY(2)) dut_s (
        .clk(clk), .reset(rst), .start(start_s), .pixelValid(pv_s), .pixelReady(pr_s),
        .adderEnable(ae_s),
`ifdef SEQ_BACKPRESSURE_EN
        .outReady(or_s),
`endif
        .outValid(ov_s), .outRow(orow_s), .outCol(ocol_s), .busy(busy_s), .done(done_s));

    conv_adder_sequencer dut_b (
        .clk(clk), .reset(rst), .start(start_b), .pixelValid(pv_b), .pixelReady(pr_b),
        .adderEnable(ae_b),
`ifdef SEQ_BACKPRESSURE_EN
        .outReady(or_b),
`endif
        .outValid(ov_b), .outRow(orow_b), .outCol(ocol_b), .busy(busy_b), .done(done_b));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // ---- monitors (sample on negedge) ----
    int   cyc = 0;
    logic clr = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_s, n_res_s, done_cnt_s, first_ov_s, acc22_s, last_acc_s, done_cyc_s, gap_bad_s;
    int res_r_s [16];
    int res_c_s [16];
    int acc_b, n_res_b, done_cnt_b, first_r_b, first_c_b, last_r_b, last_c_b;

    always @(negedge clk) begin
        if (clr) begin
            acc_s = 0; n_res_s = 0; done_cnt_s = 0; first_ov_s = -1; acc22_s = -100;
            last_acc_s = -100; done_cyc_s = -1; gap_bad_s = 0;
            acc_b = 0; n_res_b = 0; done_cnt_b = 0;
            first_r_b = -1; first_c_b = -1; last_r_b = -1; last_c_b = -1;
        end else begin
            if (pv_s && pr_s) begin
                if (acc_s == 10) acc22_s = cyc;
                if (acc_s == 15) last_acc_s = cyc;
                acc_s++;
            end
            if (ov_s && first_ov_s < 0) first_ov_s = cyc;
            if (ov_s && ae_s) begin
                if (n_res_s < 16) begin
                    res_r_s[n_res_s] = int'(orow_s);
                    res_c_s[n_res_s] = int'(ocol_s);
                end
                n_res_s++;
            end
            if (done_s) begin done_cnt_s++; done_cyc_s = cyc; end
            if (pr_s && !pv_s && ae_s) gap_bad_s++;

            if (pv_b && pr_b) acc_b++;
            if (ov_b && ae_b) begin
                if (n_res_b == 0) begin first_r_b = int'(orow_b); first_c_b = int'(ocol_b); end
                last_r_b = int'(orow_b);
                last_c_b = int'(ocol_b);
                n_res_b++;
            end
            if (done_b) done_cnt_b++;
        end
    end

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic start_small();
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        chk("busy_after_start", busy_s, 1);
        chk("ready_after_start", pr_s, 1);
    endtask

    task automatic feed_small(input bit tog, input int stop_at);
        for (int i = 0; i < 200 && acc_s < stop_at; i++) begin
            pv_s = tog ? (i % 2 == 0) : 1'b1;
            @(posedge clk); #1;
        end
        pv_s = 1'b0;
    endtask

    task automatic wait_done_small(input string nm);
        for (int i = 0; i < 50 && done_cnt_s == 0; i++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_busy_after_done"}, busy_s, 0);
        chk({nm, "_done_one_cycle"}, done_s, 0);
    endtask

    task automatic verify_small(input string nm, input bit lat_chk);
        int er [4];
        int ec [4];
        er = '{0, 0, 1, 1};
        ec = '{0, 1, 0, 1};
        chk({nm, "_accepts"}, acc_s, 16);
        chk({nm, "_results"}, n_res_s, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_row%0d", nm, i), res_r_s[i], er[i]);
            chk($sformatf("%s_col%0d", nm, i), res_c_s[i], ec[i]);
        end
        if (lat_chk) chk({nm, "_first_lat"}, first_ov_s - acc22_s, 2);
        chk({nm, "_done_lat"}, done_cyc_s - last_acc_s, 3);
        chk({nm, "_done_cnt"}, done_cnt_s, 1);
        chk({nm, "_gap_enable"}, gap_bad_s, 0);
    endtask

    initial begin
        bit hit;
        #1 rst = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pixelReady", pr_s, 0);
        chk("rst_adderEnable", ae_s, 0);
        chk("rst_outValid", ov_s, 0);
        chk("rst_outRow", orow_s, 0);
        chk("rst_outCol", ocol_s, 0);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        rst = 1'b1;

        // continuous pixels
        clear_mon();
        start_small();
        feed_small(1'b0, 16);
        wait_done_small("t1");
        verify_small("t1", 1'b1);

        // pixelValid toggling
        clear_mon();
        start_small();
        feed_small(1'b1, 16);
        wait_done_small("t2");
        verify_small("t2", 1'b0);

`ifdef SEQ_BACKPRESSURE_EN
        // hold off the first result for 5 cycles
        clear_mon();
        or_s = 1'b0;
        start_small();
        pv_s = 1'b1;
        for (int i = 0; i < 100 && !ov_s; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_outValid", ov_s, 1);
            chk("bp_outRow", orow_s, 0);
            chk("bp_outCol", ocol_s, 0);
            chk("bp_pixelReady", pr_s, 0);
            chk("bp_adderEnable", ae_s, 0);
            @(posedge clk); #1;
        end
        or_s = 1'b1;
        feed_small(1'b0, 16);
        wait_done_small("bp");
        verify_small("bp", 1'b1);
`endif

        // reset once pixel (2,2) has been accepted
        clear_mon();
        start_small();
        feed_small(1'b0, 11);
        rst = 1'b0;
        #1;
        chk("mid_rst_pixelReady", pr_s, 0);
        chk("mid_rst_adderEnable", ae_s, 0);
        chk("mid_rst_outValid", ov_s, 0);
        chk("mid_rst_outRow", orow_s, 0);
        chk("mid_rst_outCol", ocol_s, 0);
        chk("mid_rst_busy", busy_s, 0);
        chk("mid_rst_done", done_s, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_idle", busy_s, 0);
        chk("mid_rst_no_done", done_cnt_s, 0);
        clear_mon();
        start_small();
        feed_small(1'b0, 16);
        wait_done_small("t4");
        verify_small("t4", 1'b1);

        // default frame, start pulsed in RUN and in the DONE cycle
        clear_mon();
        pv_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start_b = (i == 100);
            if (done_b) begin
                start_b = 1'b1;
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("big_done_seen", hit, 1);
        @(posedge clk); #1 start_b = 1'b0;
        chk("big_start_in_done", busy_b, 0);
        @(posedge clk); #1;
        chk("big_stays_idle", busy_b, 0);
        pv_b = 1'b0;
        chk("big_accepts", acc_b, 784);
        chk("big_results", n_res_b, 676);
        chk("big_first_row", first_r_b, 0);
        chk("big_first_col", first_c_b, 0);
        chk("big_last_row", last_r_b, 25);
        chk("big_last_col", last_c_b, 25);
        chk("big_done_cnt", done_cnt_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_adder_sequencer.md
# conv_adder_sequencer

Controller that sequences the shared convolution adder stages over one input feature map. It accepts a raster-order pixel stream and gates the adder pipeline's enable. It tracks which pipeline slots hold a complete K×K window result and emits each result's valid strobe with its output coordinates. It sits between the pixel fetch logic and the adder-stage chain in convolution stage 1 and raises a done pulse per frame.

## Interface
- IMG_WIDTH, 28, input columns per row (≥ KERNEL)
- IMG_HEIGHT, 28, input rows per frame (≥ KERNEL)
- KERNEL, 3, kernel edge size (≥ 2)
- ADD_LATENCY, 2, register stages in the adder chain (≥ 1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a frame; sampled in IDLE only
- pixelValid  input  1  pixel present on fetch side
- pixelReady  output  1  sequencer accepts pixel this cycle
- adderEnable  output  1  advance adder pipeline this cycle
- outReady  input  1  downstream accepts result (only with SEQ_BACKPRESSURE_EN)
- outValid  output  1  adder output holds a valid window result
- outRow  output  $clog2(IMG_HEIGHT)  output-map row of current result
- outCol  output  $clog2(IMG_WIDTH)  output-map column of current result
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last result leaves

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start. Counters row and col are cleared.
- RUN:
  - pixelReady = 1 unless stalled.
  - accept = pixelValid & pixelReady.
  - On accept, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments.
- A window is complete on accept when row ≥ KERNEL-1 and col ≥ KERNEL-1.
  - The tag {windowValid, row-(KERNEL-1), col-(KERNEL-1)} enters the slot-0 shift register.
- adderEnable = accept in RUN, or pipeline-advance in DRAIN. The pipeline only shifts when adderEnable = 1.
- The final pixel is (IMG_HEIGHT-1, IMG_WIDTH-1). Accepting it moves the FSM RUN → DRAIN.
- DRAIN:
  - pixelReady = 0.
  - adderEnable = 1 (when not stalled) until all ADD_LATENCY tag slots are empty. Bubbles are shifted in.
  - Then DRAIN → DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- outValid, outRow and outCol are driven directly from the last tag slot.
- A frame yields (IMG_HEIGHT-KERNEL+1)·(IMG_WIDTH-KERNEL+1) results (676 at the defaults).
- start outside IDLE is ignored. start in the DONE cycle is ignored.
- reset asserted mid-frame: immediate return to IDLE. All tags and counters are cleared and no done pulse is produced.
- Results are not counted internally. Completion is defined by the last pixel having been accepted plus an empty pipeline.

## Timing
- Reset values:
  - pixelReady = 0, adderEnable = 0, outValid = 0
  - outRow = 0, outCol = 0
  - busy = 0, done = 0
  - state = IDLE, all tag slots invalid
- start at cycle t: busy = 1 and pixelReady = 1 from t+1.
- Latency: accept of a window-completing pixel at cycle t gives outValid = 1 at t+ADD_LATENCY, when there is no stall. The tag advances in lock-step with the adder data.
- Last accept at t: done = 1 at t+ADD_LATENCY+1, when there is no stall. busy falls in the same cycle that done falls.
- pixelReady and adderEnable are combinational from state, stall and pixelValid. All other outputs are registered.
- A pixelValid gap inserts no bubble into the adder pipeline: the pipeline holds, because adderEnable = 0.

## Configuration
- SEQ_BACKPRESSURE_EN defined:
  - The outReady port exists.
  - stall = outValid & ~outReady.
  - While stalled: pixelReady = 0 and adderEnable = 0, the tag pipeline holds, and outValid/outRow/outCol stay stable.
  - A result is consumed on outValid & outReady.
- SEQ_BACKPRESSURE_EN undefined:
  - There is no outReady port and stall = 0.
  - Results are presented for one adderEnable cycle and must be captured by downstream. A result stays presented until the next adderEnable.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - the tag struct {valid, row, col}
  - default IMG_WIDTH, IMG_HEIGHT, KERNEL and ADD_LATENCY constants
- One natural sub-module: conv_tag_pipe, the ADD_LATENCY-deep shift register of tags with enable and an "empty" flag.
- The FSM and raster counters stay in the top module.

## Test plan
- Run with IMG_WIDTH = 4, IMG_HEIGHT = 4, KERNEL = 3, ADD_LATENCY = 2, and pixelValid held high. Pulse start, then feed 16 pixels. Required: exactly 4 outValid pulses with (row, col) = (0,0), (0,1), (1,0), (1,1). The first appears 2 cycles after pixel (2,2) is accepted. done appears 3 cycles after pixel (3,3) is accepted.
- Repeat the first scenario with pixelValid toggling 1,0,1,0. Required: the same 4 results in the same order, adderEnable = 0 on every gap cycle, and no extra outValid.
- Under SEQ_BACKPRESSURE_EN, hold outReady = 0 for 5 cycles at the first result. Required: outValid = 1 with (0,0) stable, pixelReady = 0 and adderEnable = 0 for those 5 cycles; then normal resumption and 4 results in total.
- Assert reset at pixel 10 of a frame. Required: all outputs equal 0 next cycle, state is IDLE, and no done pulse. A fresh start afterwards gives the full correct 4-result frame.
- Pulse start while in RUN and in the DONE cycle. Required: ignored, with no counter reset. In the default 28×28 frame, start is accepted only from IDLE and there are exactly 676 outValid pulses.
